// File: rtl/dmem_responder_pkg.sv
// Shared widths, state encoding and helpers for the D-memory responder.
package dmem_responder_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/dmem_responder_byte_merge.sv
// Byte-lane merge: enabled lanes take the new word, the rest keep the old word.
module dmem_responder_byte_merge
    import dmem_responder_pkg::*;
(
    input  logic [WORD_W-1:0] old_i,
    input  logic [WORD_W-1:0] new_i,
    input  logic [BE_W-1:0]   be_i,
    output logic [WORD_W-1:0] merged_o
);

    // Per-lane select between stored and incoming byte.
    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < BE_W; i++) begin
            if (be_i[i]) begin
                merged_o[8*i +: 8] = new_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Target end of the core's D-memory port: word storage with byte-enable writes,
// one-cycle registered read data, post-reset clear sweep, access counters and
// a sticky out-of-range flag.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH          = 1024,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter string       INIT_FILE      = ""
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              D_MEM_CSN,
    input  logic              D_MEM_WEN,
    input  logic [BE_W-1:0]   D_MEM_BE,
    input  logic [ADDR_W-1:0] D_MEM_ADDR,
    input  logic [WORD_W-1:0] D_MEM_DOUT,
    output logic [WORD_W-1:0] D_MEM_DI,
    output logic              READY,
    output logic              ERR,
    output logic [CNT_W-1:0]  RD_CNT,
    output logic [CNT_W-1:0]  WR_CNT
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_W-1:0] mem_q [DEPTH];

    state_e            state_q;
    logic [IDX_W-1:0]  clr_ptr_q;
    logic [WORD_W-1:0] di_q;
    logic              err_q;
    logic [CNT_W-1:0]  rd_cnt_q;
    logic [CNT_W-1:0]  wr_cnt_q;

    logic [9:0]        word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              in_range;
    logic [WORD_W-1:0] old_word;
    logic [WORD_W-1:0] merged_word;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [WORD_W-1:0] mem_wdata;
    logic              unused_addr_lsb;

    assign word_idx        = D_MEM_ADDR[11:2];
    assign unused_addr_lsb = ^D_MEM_ADDR[1:0];
    assign in_range        = 32'(word_idx) < DEPTH;
    assign mem_idx         = word_idx[IDX_W-1:0];
    assign old_word        = mem_q[mem_idx];

    dmem_responder_byte_merge u_byte_merge (
        .old_i    (old_word),
        .new_i    (D_MEM_DOUT),
        .be_i     (D_MEM_BE),
        .merged_o (merged_word)
    );

    // Single memory write port shared by the clear sweep and core writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = mem_idx;
        mem_wdata = merged_word;
        if (RSTn) begin
            if (state_q == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
            end else if (!D_MEM_CSN && in_range && !D_MEM_WEN) begin
                mem_we = 1'b1;
            end
        end
    end

    // Storage array; reset intentionally leaves contents alone.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM with registered read data, error flag and counters.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_ptr_q <= '0;
            di_q      <= '0;
            err_q     <= 1'b0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + IDX_W'(1);
                    if (clr_ptr_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!D_MEM_CSN) begin
                        if (!in_range) begin
                            err_q <= 1'b1;
                            di_q  <= '0;
                        end else if (!D_MEM_WEN) begin
                            di_q     <= merged_word;  // write-first
                            wr_cnt_q <= sat_inc(wr_cnt_q);
                        end else begin
                            di_q     <= old_word;
                            rd_cnt_q <= sat_inc(rd_cnt_q);
                        end
                    end
                end
            endcase
        end
    end

    assign READY    = (state_q == ST_RUN);
    assign D_MEM_DI = di_q;
    assign ERR      = err_q;
    assign RD_CNT   = rd_cnt_q;
    assign WR_CNT   = wr_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (1024 and 256 words)
// share one stimulus stream and are checked against an array-based model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rstn, csn, wen;
    logic [3:0]  be;
    logic [11:0] addr;
    logic [31:0] dout;

    logic [31:0] a_di, b_di;
    logic        a_ready, b_ready, a_err, b_err;
    logic [15:0] a_rd, b_rd, a_wr, b_wr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH(1024), .CLEAR_ON_RESET(1'b1), .INIT_FILE("")) u_dut_a (
        .CLK(clk), .RSTn(rstn), .D_MEM_CSN(csn), .D_MEM_WEN(wen), .D_MEM_BE(be),
        .D_MEM_ADDR(addr), .D_MEM_DOUT(dout), .D_MEM_DI(a_di), .READY(a_ready),
        .ERR(a_err), .RD_CNT(a_rd), .WR_CNT(a_wr)
    );

    dmem_responder #(.DEPTH(256), .CLEAR_ON_RESET(1'b1), .INIT_FILE("")) u_dut_b (
        .CLK(clk), .RSTn(rstn), .D_MEM_CSN(csn), .D_MEM_WEN(wen), .D_MEM_BE(be),
        .D_MEM_ADDR(addr), .D_MEM_DOUT(dout), .D_MEM_DI(b_di), .READY(b_ready),
        .ERR(b_err), .RD_CNT(b_rd), .WR_CNT(b_wr)
    );

    // Reference model state, one slot per instance.
    logic [31:0] m_mem [2][1024];
    logic [31:0] m_di  [2];
    logic        m_err [2];
    logic [15:0] m_rd  [2];
    logic [15:0] m_wr  [2];
    int          m_left[2];  // clear cycles still to go; 0 means ready

    typedef struct {
        int          cycle;
        logic [31:0] di0, di1;
        logic        err0, err1, rdy0, rdy1;
        logic [15:0] rd0, rd1, wr0, wr1;
    } exp_t;

    exp_t q[$];

    function automatic int depth(input int u);
        return (u == 0) ? 1024 : 256;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Advance the model of instance u across one clock edge.
    task automatic model_step(input int u);
        int          idx;
        logic [31:0] mask;
        if (!rstn) begin
            m_left[u] = depth(u);
            m_di[u]   = '0;
            m_err[u]  = 1'b0;
            m_rd[u]   = '0;
            m_wr[u]   = '0;
        end else if (m_left[u] > 0) begin
            m_left[u]--;
            if (m_left[u] == 0) begin
                for (int i = 0; i < depth(u); i++) m_mem[u][i] = '0;
            end
        end else if (!csn) begin
            idx = int'(addr) / 4;
            if (idx >= depth(u)) begin
                m_err[u] = 1'b1;
                m_di[u]  = '0;
            end else if (!wen) begin
                mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                m_mem[u][idx] = (m_mem[u][idx] & ~mask) | (dout & mask);
                m_di[u] = m_mem[u][idx];
                if (m_wr[u] != 16'hFFFF) m_wr[u]++;
            end else begin
                m_di[u] = m_mem[u][idx];
                if (m_rd[u] != 16'hFFFF) m_rd[u]++;
            end
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs after the edge.
    task automatic cycle(input logic r, input logic c, input logic w, input logic [3:0] b,
                         input logic [11:0] a, input logic [31:0] d);
        exp_t e;
        rstn = r; csn = c; wen = w; be = b; addr = a; dout = d;
        model_step(0);
        model_step(1);
        e.cycle = cyc + 1;
        e.di0 = m_di[0];  e.di1 = m_di[1];
        e.err0 = m_err[0]; e.err1 = m_err[1];
        e.rdy0 = (m_left[0] == 0); e.rdy1 = (m_left[1] == 0);
        e.rd0 = m_rd[0];  e.rd1 = m_rd[1];
        e.wr0 = m_wr[0];  e.wr1 = m_wr[1];
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b1, 1'b1, 1'b1, 4'h0, 12'h000, 32'h0);
    endtask

    task automatic rst();
        cycle(1'b0, 1'b1, 1'b1, 4'h0, 12'h000, 32'h0);
    endtask

    // Monitor: compare every queued expectation on the falling edge of its cycle.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cycle <= cyc) begin
            e = q.pop_front();
            if (e.cycle < cyc) begin
                total++;
                bad++;
                $display("FAIL stale_entry: got cycle %0d expected cycle %0d", cyc, e.cycle);
            end else begin
                chk("a_di", a_di, e.di0);
                chk("a_err", 32'(a_err), 32'(e.err0));
                chk("a_ready", 32'(a_ready), 32'(e.rdy0));
                chk("a_rd_cnt", 32'(a_rd), 32'(e.rd0));
                chk("a_wr_cnt", 32'(a_wr), 32'(e.wr0));
                chk("b_di", b_di, e.di1);
                chk("b_err", 32'(b_err), 32'(e.err1));
                chk("b_ready", 32'(b_ready), 32'(e.rdy1));
                chk("b_rd_cnt", 32'(b_rd), 32'(e.rd1));
                chk("b_wr_cnt", 32'(b_wr), 32'(e.wr1));
            end
        end
    end

    initial begin
        logic        c, w;
        logic [11:0] a;
        rstn = 1'b0; csn = 1'b1; wen = 1'b1; be = '0; addr = '0; dout = '0;
        for (int u = 0; u < 2; u++) begin
            m_left[u] = 0; m_di[u] = '0; m_err[u] = 1'b0; m_rd[u] = '0; m_wr[u] = '0;
            for (int i = 0; i < 1024; i++) m_mem[u][i] = '0;
        end
        @(posedge clk);
        #1;

        // Reset and full clear sweep of the 1024-word instance.
        repeat (3) rst();
        chk("reset_ready", 32'(a_ready), 32'h0);
        chk("reset_di", a_di, 32'h0);
        repeat (1023) idle();
        chk("clear_1023_ready", 32'(a_ready), 32'h0);
        idle();
        chk("clear_1024_ready", 32'(a_ready), 32'h1);

        // Cleared word reads back zero.
        cycle(1'b1, 1'b0, 1'b1, 4'hF, 12'h014, 32'h0);
        chk("rd5_di", a_di, 32'h0);
        chk("rd5_rdcnt", 32'(a_rd), 32'h1);

        // Full-word write then read back.
        cycle(1'b1, 1'b0, 1'b0, 4'hF, 12'h010, 32'hDEADBEEF);
        cycle(1'b1, 1'b0, 1'b1, 4'hF, 12'h010, 32'h0);
        chk("rw_di", a_di, 32'hDEADBEEF);
        chk("rw_wrcnt", 32'(a_wr), 32'h1);

        // Partial byte-enable merge, then an empty-enable write.
        cycle(1'b1, 1'b0, 1'b0, 4'hF, 12'h020, 32'h11223344);
        cycle(1'b1, 1'b0, 1'b0, 4'h5, 12'h022, 32'hAABBCCDD);
        cycle(1'b1, 1'b0, 1'b1, 4'h0, 12'h020, 32'h0);
        chk("merge_di", a_di, 32'h11BB33DD);
        cycle(1'b1, 1'b0, 1'b0, 4'h0, 12'h020, 32'hFFFFFFFF);
        cycle(1'b1, 1'b0, 1'b1, 4'hF, 12'h020, 32'h0);
        chk("be0_di", a_di, 32'h11BB33DD);
        chk("be0_wrcnt", 32'(a_wr), 32'h4);

        // Word 256 is out of range only for the 256-word instance.
        cycle(1'b1, 1'b0, 1'b1, 4'hF, 12'h400, 32'h0);
        chk("oor_err", 32'(b_err), 32'h1);
        chk("oor_di", b_di, 32'h0);
        chk("oor_rdcnt", 32'(b_rd), 32'h4);
        chk("inrange_err", 32'(a_err), 32'h0);
        idle();
        idle();
        chk("err_sticky", 32'(b_err), 32'h1);

        // Random traffic, biased toward a small window to revisit written words.
        for (int i = 0; i < 2000; i++) begin
            c = ($urandom_range(0, 9) < 7) ? 1'b0 : 1'b1;
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 63)) : 12'($urandom);
            cycle(1'b1, c, w, 4'($urandom), a, $urandom);
        end

        // Reset in the middle of a clear restarts the full sweep; writes are dropped.
        repeat (2) rst();
        repeat (300) idle();
        chk("midclear_ready", 32'(a_ready), 32'h0);
        repeat (2) rst();
        for (int i = 0; i < 1024; i++) begin
            if (i == 500) cycle(1'b1, 1'b0, 1'b0, 4'hF, 12'h030, 32'h12345678);
            else idle();
            if (i == 1022) chk("reclear_1023_ready", 32'(a_ready), 32'h0);
        end
        chk("reclear_ready", 32'(a_ready), 32'h1);
        chk("dropped_wrcnt", 32'(a_wr), 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 4'hF, 12'h030, 32'h0);
        chk("dropped_word", a_di, 32'h0);

        // Read counter saturation.
        for (int i = 0; i < 70000; i++) cycle(1'b1, 1'b0, 1'b1, 4'hF, 12'h000, 32'h0);
        chk("rdcnt_sat", 32'(a_rd), 32'h0000FFFF);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
